// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words and
// writes them to sequential word addresses from 0, holding the CPU while a session runs.
module imem_loader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FullCnt  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StFlush, StDone} state_e;

    state_e     state;
    logic [1:0] byte_idx;
    logic       full;
    logic       take;

    assign full = (word_cnt == FullCnt);
    assign take = rx_valid && rx_ready && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            byte_idx   <= 2'd0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (load_en) begin
                        state      <= StCollect;
                        rx_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        imem_addr  <= '0;
                        imem_wdata <= 32'd0;
                        word_cnt   <= '0;
                        byte_idx   <= 2'd0;
                        overflow   <= 1'b0;
                    end
                end
                StCollect: begin
                    if (rx_valid && full) begin
                        overflow <= 1'b1;
                    end
                    if (take) begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    if (take && byte_idx == 2'd3) begin
                        state    <= StWrite;
                        rx_ready <= 1'b0;
                        imem_we  <= 1'b1;
                    end else if (!load_en) begin
                        rx_ready <= 1'b0;
                        // A byte accepted on the falling cycle still counts as a partial word.
                        if (take || byte_idx != 2'd0) begin
                            state   <= StFlush;
                            imem_we <= 1'b1;
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end
                end
                StWrite, StFlush: begin
                    word_cnt   <= word_cnt + 1'b1;
                    byte_idx   <= 2'd0;
                    imem_wdata <= 32'd0;
                    if (imem_addr != LastAddr) begin
                        imem_addr <= imem_addr + 1'b1;
                    end
                    if (state == StWrite && load_en) begin
                        state    <= StCollect;
                        rx_ready <= 1'b1;
                    end else begin
                        state <= StDone;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-depth instance plus a DEPTH=4 instance for capacity.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic        load_en4 = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    logic        rdy, we, hold, dn, ovf;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [14:0] wcnt;
    logic        rdy4, we4, hold4, dn4, ovf4;
    logic [13:0] addr4;
    logic [31:0] wdata4;
    logic [14:0] wcnt4;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] wa[$];
    logic [31:0] wd[$];
    logic [13:0] wa4[$];
    logic [31:0] wd4[$];
    int          done_cnt = 0;
    int          done_cnt4 = 0;
    int          bad_rdy = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy), .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
        .cpu_hold(hold), .done(dn), .word_cnt(wcnt), .overflow(ovf)
    );

    imem_loader #(.ADDR_W(14), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en4), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy4), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
        .cpu_hold(hold4), .done(dn4), .word_cnt(wcnt4), .overflow(ovf4)
    );

    always @(negedge clk) begin
        if (we) begin
            wa.push_back(addr);
            wd.push_back(wdata);
            if (rdy) bad_rdy++;
        end
        if (we4) begin
            wa4.push_back(addr4);
            wd4.push_back(wdata4);
        end
        if (dn) done_cnt++;
        if (dn4) done_cnt4++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
        done_cnt = 0; done_cnt4 = 0; bad_rdy = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit to4);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!(to4 ? rdy4 : rdy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL send_byte timeout: rx_ready stayed 0 for byte %h, required 1", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({rdy, we, addr, wdata, hold, dn, wcnt, ovf} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {rdy, we, addr, wdata, hold, dn, wcnt, ovf});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rdy4, we4, addr4, wdata4, hold4, dn4, wcnt4, ovf4} !== 67'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h required 0",
                     {rdy4, we4, addr4, wdata4, hold4, dn4, wcnt4, ovf4});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
        clear_mon();
        load_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({hold, rdy} !== 2'b11) begin
            n_err++;
            $display("FAIL session_start hold/ready: got %b required 11", {hold, rdy});
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], 1'b0);
            if (i == 3) begin
                n_cmp++;
                if ({we, rdy, addr, wdata} !== {1'b1, 1'b0, 14'd0, 32'h0000_0013}) begin
                    n_err++;
                    $display("FAIL write_latency: got we=%b rdy=%b addr=%h data=%h required 1 0 0 00000013",
                             we, rdy, addr, wdata);
                end
            end
        end
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wa.size() != 2) begin
            n_err++;
            $display("FAIL b2b_write_count: got %0d required 2", wa.size());
        end
        n_cmp++;
        if ({wa[0], wd[0]} !== {14'd0, 32'h0000_0013}) begin
            n_err++;
            $display("FAIL b2b_word0: got %h/%h required 0000/00000013", wa[0], wd[0]);
        end
        n_cmp++;
        if ({wa[1], wd[1]} !== {14'd1, 32'h0020_80B3}) begin
            n_err++;
            $display("FAIL b2b_word1: got %h/%h required 0001/002080b3", wa[1], wd[1]);
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_err++;
            $display("FAIL b2b_ready_in_write: got %0d write cycles with rx_ready=1 required 0", bad_rdy);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL b2b_done_pulses: got %0d required 1", done_cnt);
        end
        n_cmp++;
        if ({wcnt, ovf, hold} !== {15'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_final: got cnt=%0d ovf=%b hold=%b required 2 0 0", wcnt, ovf, hold);
        end
    endtask

    task automatic test_flush();
        clear_mon();
        load_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b0);
        load_en = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (wa.size() != 2) begin
            n_err++;
            $display("FAIL flush_write_count: got %0d required 2", wa.size());
        end
        n_cmp++;
        if ({wa[0], wd[0]} !== {14'd0, 32'h1413_1211}) begin
            n_err++;
            $display("FAIL flush_word0: got %h/%h required 0000/14131211", wa[0], wd[0]);
        end
        n_cmp++;
        if ({wa[1], wd[1]} !== {14'd1, 32'h0000_1615}) begin
            n_err++;
            $display("FAIL flush_partial: got %h/%h required 0001/00001615", wa[1], wd[1]);
        end
        n_cmp++;
        if ({wcnt, done_cnt[1:0]} !== {15'd2, 2'd1}) begin
            n_err++;
            $display("FAIL flush_cnt_done: got cnt=%0d done=%0d required 2 1", wcnt, done_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
        clear_mon();
        load_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(b[i], 1'b0);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wa.size() != 2) begin
            n_err++;
            $display("FAIL gaps_write_count: got %0d required 2", wa.size());
        end
        n_cmp++;
        if ({wa[0], wd[0], wa[1], wd[1]} !== {14'd0, 32'h0000_0013, 14'd1, 32'h0020_80B3}) begin
            n_err++;
            $display("FAIL gaps_words: got %h/%h %h/%h required 0000/00000013 0001/002080b3",
                     wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_capacity();
        logic [31:0] exp_w [4] = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        clear_mon();
        load_en4 = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            send_byte(8'(k), 1'b1);
            if (k == 16) begin
                n_cmp++;
                if (ovf4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL cap_ovf_early: got %b after byte 16 required 0", ovf4);
                end
            end
            if (k == 17) begin
                n_cmp++;
                if (ovf4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL cap_ovf_set: got %b after byte 17 required 1", ovf4);
                end
            end
        end
        load_en4 = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wa4.size() != 4) begin
            n_err++;
            $display("FAIL cap_write_count: got %0d required 4", wa4.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({wa4[i], wd4[i]} !== {14'(i), exp_w[i]}) begin
                n_err++;
                $display("FAIL cap_word%0d: got %h/%h required %h/%h", i, wa4[i], wd4[i], 14'(i), exp_w[i]);
            end
        end
        n_cmp++;
        if ({wcnt4, ovf4, done_cnt4[1:0]} !== {15'd4, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL cap_final: got cnt=%0d ovf=%b done=%0d required 4 1 1", wcnt4, ovf4, done_cnt4);
        end
        n_cmp++;
        if (wa.size() != 0) begin
            n_err++;
            $display("FAIL cap_isolation: default instance wrote %0d words required 0", wa.size());
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        clear_mon();
        load_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(b[i], 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rdy, we, addr, wdata, hold, dn, wcnt, ovf} !== 67'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h required 0", {rdy, we, addr, wdata, hold, dn, wcnt, ovf});
        end
        load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wa.size() != 1 || {wa[0], wd[0]} !== {14'd0, 32'hA4A3_A2A1}) begin
            n_err++;
            $display("FAIL abort_no_partial: got %0d writes, first %h/%h required 1 write 0000/a4a3a2a1",
                     wa.size(), wa[0], wd[0]);
        end
        clear_mon();
        load_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i), 1'b0);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wa.size() != 1 || {wa[0], wd[0], wcnt} !== {14'd0, 32'hC4C3_C2C1, 15'd1}) begin
            n_err++;
            $display("FAIL abort_new_session: got %0d writes, %h/%h cnt=%0d required 1 0000/c4c3c2c1 1",
                     wa.size(), wa[0], wd[0], wcnt);
        end
    endtask

    task automatic test_idle();
        logic seen_rdy = 1'b0;
        logic seen_we = 1'b0;
        logic seen_hold = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_valid = i[0];
            rx_data  = 8'(i);
            @(negedge clk);
            seen_rdy  |= rdy;
            seen_we   |= we;
            seen_hold |= hold;
        end
        rx_valid = 1'b0;
        n_cmp++;
        if ({seen_rdy, seen_we, seen_hold} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_quiet: got rdy/we/hold seen=%b required 000", {seen_rdy, seen_we, seen_hold});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flush();
        test_gaps();
        test_capacity();
        test_reset_abort();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of instruction fetch: fills instruction memory with a program before/while the CPU is held.
- Takes a byte stream (from the UART RX block), packs 4 bytes little-endian into 32-bit words, and issues single-cycle write strobes to the instruction memory write port at sequential 14-bit word addresses starting at 0.
- Drives cpu_hold so the fetch unit does not advance the PC while loading.

Parameters:
- ADDR_W, 14, word-address width; matches the fetch address width.
- DEPTH, 16384, number of writable words; must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_en  input  1  level; high = loading session active
- rx_valid  input  1  rx_data holds a byte this cycle
- rx_data  input  8  received byte
- rx_ready  output  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
- imem_we  output  1  one-cycle write strobe to instruction memory
- imem_addr  output  ADDR_W  word address for the write
- imem_wdata  output  32  word to write
- cpu_hold  output  1  high while state != IDLE; CPU/PC frozen
- done  output  1  one-cycle pulse when a session completes
- word_cnt  output  ADDR_W+1  number of words written in the current/last session
- overflow  output  1  sticky; a byte arrived after DEPTH words were written

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0. byte_idx=0, shift register=0, addr counter=0.
- States: IDLE, COLLECT, WRITE, FLUSH, DONE.
- IDLE: rx_ready=0. On load_en=1 -> COLLECT; clear addr counter, word_cnt, byte_idx, overflow.
- COLLECT: rx_ready=1. On transfer, place rx_data at byte lane byte_idx (byte 0 -> bits 7:0, byte 3 -> bits 31:24), then byte_idx++. On the 4th byte -> WRITE.
- WRITE: one cycle. rx_ready=0; imem_we=1; imem_addr=addr counter; imem_wdata=assembled word. Next edge: addr++, word_cnt++, byte_idx=0, lanes cleared; -> COLLECT if load_en=1, else DONE.
- Latency: imem_we asserts in the cycle after the edge that accepted byte 3. Maximum throughput is one byte per cycle plus one stall cycle per word.
- load_en falls in COLLECT:
  - If byte_idx=0 -> DONE.
  - Otherwise -> FLUSH: write the partial word with unfilled lanes = 0 (imem_we=1 for one cycle, counters update as in WRITE) -> DONE.
  - A transfer in the same cycle load_en falls is still accepted.
- DONE: done=1 for one cycle; rx_ready=0; -> IDLE. word_cnt and overflow hold until the next session starts.
- Capacity:
  - When word_cnt = DEPTH, COLLECT keeps rx_ready=1 but discards bytes, sets overflow=1, and issues no writes.
  - addr never wraps past DEPTH-1.
- load_en rising while in DONE is ignored until IDLE (a new session starts on the IDLE cycle).
- cpu_hold = 1 in COLLECT, WRITE, FLUSH, and DONE; 0 in IDLE.
- rst_n asserted mid-session aborts immediately to IDLE with all outputs 0. A partial word is not written.

Test Plan:
- Load 8 bytes 0x13,0x00,0x00,0x00,0xB3,0x80,0x20,0x00 back-to-back, then drop load_en -> writes 0x00000013 @0 and 0x002080B3 @1; rx_ready low on each WRITE cycle; done pulses once; word_cnt=2; overflow=0.
- Load 6 bytes 0x11..0x16, drop load_en -> writes 0x14131211 @0, then FLUSH writes 0x00001615 @1; word_cnt=2.
- Bytes with random rx_valid gaps (0-3 idle cycles) -> same words and addresses as the gap-free run; no extra imem_we.
- DEPTH=4 override; send 20 bytes -> exactly 4 writes at addresses 0..3; overflow=1 after byte 17; no write to address 4.
- Pulse rst_n low after byte 2 of word 1 -> all outputs 0 asynchronously; no write for the partial word. New session then writes its first word at address 0.
- load_en held low, rx_valid toggling -> rx_ready=0, imem_we never asserted, cpu_hold=0.
